// File: rtl/popcount_l2_cfu.sv
// Population-count custom function unit with a two-stage pipeline.
// Supports POPCNT, POPAND, HAMMING, a running count accumulator (ACC) and
// read-and-clear of that accumulator (RDCLR). Unused function IDs answer
// with an error status and a zero result.
//
// Handshake: a request transfers when req_valid && req_ready, and a response
// transfers when resp_valid && resp_ready. The only back-pressure source is an
// unconsumed response, so req_ready depends on the output stage alone and
// never on req_valid.

package cfu_pkg;
    localparam int CFU_STATUS_W = 2;
    localparam logic [CFU_STATUS_W-1:0] CFU_OK    = 2'd0;
    localparam logic [CFU_STATUS_W-1:0] CFU_ERROR = 2'd1;

    // Shared elaboration-time legality checks for CFU parameters.
    function automatic bit cfu_check_data_w(input int w);
        return (w == 32) || (w == 64);
    endfunction

    function automatic bit cfu_check_func_id_w(input int w);
        return (w == 3);
    endfunction
endpackage

module popcount_l2_cfu
    import cfu_pkg::*;
#(
    parameter int CFU_DATA_W    = 32,
    parameter int CFU_FUNC_ID_W = 3,
    parameter int ADDER_TREE    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [CFU_FUNC_ID_W-1:0] req_func,
    input  logic [CFU_DATA_W-1:0]    req_data0,
    input  logic [CFU_DATA_W-1:0]    req_data1,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [CFU_STATUS_W-1:0]  resp_status,
    output logic [CFU_DATA_W-1:0]    resp_data
);

    // Compressor flavour counts 6-bit groups (one 6:3 compressor each);
    // the adder-tree flavour counts byte-sized groups with pairwise adds.
    localparam int SEG_W = (ADDER_TREE != 0) ? 8 : 6;
    localparam int NSEG  = (CFU_DATA_W + SEG_W - 1) / SEG_W;
    localparam int PAD_W = NSEG * SEG_W;
    localparam int SCW   = $clog2(SEG_W + 1);
    localparam int CW    = $clog2(CFU_DATA_W + 1);

    localparam logic [CFU_FUNC_ID_W-1:0] FUNC_POPCNT  = CFU_FUNC_ID_W'(0);
    localparam logic [CFU_FUNC_ID_W-1:0] FUNC_POPAND  = CFU_FUNC_ID_W'(1);
    localparam logic [CFU_FUNC_ID_W-1:0] FUNC_HAMMING = CFU_FUNC_ID_W'(2);
    localparam logic [CFU_FUNC_ID_W-1:0] FUNC_ACC     = CFU_FUNC_ID_W'(3);
    localparam logic [CFU_FUNC_ID_W-1:0] FUNC_RDCLR   = CFU_FUNC_ID_W'(4);

    if (!cfu_check_data_w(CFU_DATA_W)) begin : g_bad_data_w
        $error("popcount_l2_cfu: CFU_DATA_W must be 32 or 64");
    end
    if (!cfu_check_func_id_w(CFU_FUNC_ID_W)) begin : g_bad_func_id_w
        $error("popcount_l2_cfu: CFU_FUNC_ID_W must be 3");
    end

    function automatic logic [SCW-1:0] count_seg(input logic [SEG_W-1:0] s);
        logic [SCW-1:0] c;
        c = '0;
        for (int i = 0; i < SEG_W; i++) begin
            c = c + SCW'(s[i]);
        end
        return c;
    endfunction

    logic                           stall;
    logic                           advance;
    logic                           accept;
    logic [CFU_DATA_W-1:0]          operand;
    logic [PAD_W-1:0]               padded;
    logic [NSEG-1:0][SCW-1:0]       seg_cnt;

    logic                           s1_valid;
    logic [CFU_FUNC_ID_W-1:0]       s1_func;
    logic [NSEG-1:0][SCW-1:0]       s1_cnt;

    logic [CW-1:0]                  total;
    logic [CFU_DATA_W-1:0]          total_ext;
    logic [CFU_DATA_W-1:0]          acc;
    logic [CFU_DATA_W-1:0]          acc_sum;
    logic [CFU_DATA_W-1:0]          nxt_data;
    logic [CFU_DATA_W-1:0]          nxt_acc;
    logic [CFU_STATUS_W-1:0]        nxt_status;

    // A held response freezes both stages; otherwise everything moves on.
    always_comb begin
        stall     = resp_valid && !resp_ready;
        advance   = !stall;
        req_ready = !stall;
        accept    = req_valid && req_ready;
    end

    // Operand selection and per-segment partial counts for stage 1.
    always_comb begin
        operand = req_data0;
        case (req_func)
            FUNC_POPAND:  operand = req_data0 & req_data1;
            FUNC_HAMMING: operand = req_data0 ^ req_data1;
            default:      operand = req_data0;
        endcase
        padded = '0;
        padded[CFU_DATA_W-1:0] = operand;
        for (int i = 0; i < NSEG; i++) begin
            seg_cnt[i] = count_seg(padded[i*SEG_W +: SEG_W]);
        end
    end

    // Stage 1 register: a bubble is loaded when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_func  <= '0;
            s1_cnt   <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_func <= req_func;
                s1_cnt  <= seg_cnt;
            end
        end
    end

    // Final reduction and result/accumulator selection for stage 2.
    always_comb begin
        total = '0;
        for (int i = 0; i < NSEG; i++) begin
            total = total + CW'(s1_cnt[i]);
        end
        total_ext  = CFU_DATA_W'(total);
        acc_sum    = acc + total_ext;
        nxt_data   = '0;
        nxt_acc    = acc;
        nxt_status = CFU_OK;
        case (s1_func)
            FUNC_POPCNT, FUNC_POPAND, FUNC_HAMMING: nxt_data = total_ext;
            FUNC_ACC: begin
                nxt_acc  = acc_sum;
                nxt_data = acc_sum;
            end
            FUNC_RDCLR: begin
                nxt_data = acc;
                nxt_acc  = '0;
            end
            default: nxt_status = CFU_ERROR;
        endcase
    end

    // Stage 2 register: the accumulator changes only as an op lands here,
    // which keeps ACC/RDCLR results in program order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_status <= CFU_OK;
            acc         <= '0;
        end else if (advance) begin
            resp_valid <= s1_valid;
            if (s1_valid) begin
                resp_data   <= nxt_data;
                resp_status <= nxt_status;
                acc         <= nxt_acc;
            end
        end
    end

endmodule

// File: tb/tb_popcount_l2_cfu.sv
// Bench for popcount_l2_cfu: four instances (32/64-bit, compressor/tree)
// run in lockstep on the same stimulus and are scored against one model.
`timescale 1ns/1ps

module tb_popcount_l2_cfu;

    typedef struct packed {
        logic [1:0]  st;
        logic [63:0] d32;
        logic [63:0] d64;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_func;
    logic [63:0] a;
    logic [63:0] b;
    logic        resp_ready;

    wire  [3:0]  rdy;
    wire  [3:0]  rv;
    wire  [1:0]  st [4];
    wire  [31:0] rd32_c;
    wire  [31:0] rd32_t;
    wire  [63:0] rd64_c;
    wire  [63:0] rd64_t;

    exp_t        exp_q[$];
    logic [31:0] acc32;
    logic [63:0] acc64;
    int          tests_run;
    int          tests_failed;

    popcount_l2_cfu #(.CFU_DATA_W(32), .CFU_FUNC_ID_W(3), .ADDER_TREE(0)) dut_w32_c (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_func(req_func), .req_data0(a[31:0]), .req_data1(b[31:0]),
        .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_status(st[0]), .resp_data(rd32_c));

    popcount_l2_cfu #(.CFU_DATA_W(32), .CFU_FUNC_ID_W(3), .ADDER_TREE(1)) dut_w32_t (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_func(req_func), .req_data0(a[31:0]), .req_data1(b[31:0]),
        .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_status(st[1]), .resp_data(rd32_t));

    popcount_l2_cfu #(.CFU_DATA_W(64), .CFU_FUNC_ID_W(3), .ADDER_TREE(0)) dut_w64_c (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_func(req_func), .req_data0(a), .req_data1(b),
        .resp_valid(rv[2]), .resp_ready(resp_ready), .resp_status(st[2]), .resp_data(rd64_c));

    popcount_l2_cfu #(.CFU_DATA_W(64), .CFU_FUNC_ID_W(3), .ADDER_TREE(1)) dut_w64_t (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[3]),
        .req_func(req_func), .req_data0(a), .req_data1(b),
        .resp_valid(rv[3]), .resp_ready(resp_ready), .resp_status(st[3]), .resp_data(rd64_t));

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] rd_of(input int k);
        case (k)
            0:       return {32'h0, rd32_c};
            1:       return {32'h0, rd32_t};
            2:       return rd64_c;
            default: return rd64_t;
        endcase
    endfunction

    // Reference model: program-order semantics evaluated at acceptance.
    task automatic model_accept(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
        exp_t e;
        int   c32;
        int   c64;
        c32 = 0;
        c64 = 0;
        case (f)
            3'd0, 3'd3: begin c32 = $countones(x[31:0]);         c64 = $countones(x);     end
            3'd1:       begin c32 = $countones(x[31:0] & y[31:0]); c64 = $countones(x & y); end
            3'd2:       begin c32 = $countones(x[31:0] ^ y[31:0]); c64 = $countones(x ^ y); end
            default:    begin c32 = 0; c64 = 0; end
        endcase
        e.st  = cfu_pkg::CFU_OK;
        e.d32 = 64'(c32);
        e.d64 = 64'(c64);
        if (f == 3'd3) begin
            acc32 = acc32 + 32'(c32);
            acc64 = acc64 + 64'(c64);
            e.d32 = {32'h0, acc32};
            e.d64 = acc64;
        end else if (f == 3'd4) begin
            e.d32 = {32'h0, acc32};
            e.d64 = acc64;
            acc32 = '0;
            acc64 = '0;
        end else if (f > 3'd4) begin
            e.st  = cfu_pkg::CFU_ERROR;
            e.d32 = '0;
            e.d64 = '0;
        end
        exp_q.push_back(e);
    endtask

    // One clock cycle: score consumed responses and handshakes at the
    // falling edge, record accepted requests, return just after the rise.
    task automatic tick();
        exp_t        e;
        logic [63:0] got;
        logic [63:0] want;
        logic [3:0]  exp_rdy;
        @(negedge clk);
        if (resp_ready && (rv != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_resp: got resp_valid=%b, want no response", rv);
            end else begin
                e = exp_q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    got  = rd_of(k);
                    want = (k < 2) ? e.d32 : e.d64;
                    tests_run++;
                    if (rv[k] !== 1'b1 || got !== want || st[k] !== e.st) begin
                        tests_failed++;
                        $display("FAIL resp[%0d]: got v=%b d=%h s=%0d, want v=1 d=%h s=%0d",
                                 k, rv[k], got, st[k], want, e.st);
                    end
                end
            end
        end
        for (int k = 0; k < 4; k++) exp_rdy[k] = !(rv[k] && !resp_ready);
        tests_run++;
        if (rdy !== exp_rdy) begin
            tests_failed++;
            $display("FAIL req_ready: got %b, want %b", rdy, exp_rdy);
        end
        if (req_valid && rdy[0] === 1'b1) model_accept(req_func, a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || rv !== 4'b0000) && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0 || rv !== 4'b0000) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending, resp_valid=%b, want 0 pending, 0000", exp_q.size(), rv);
        end
        repeat (3) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if (rv !== 4'b0000 || rdy !== 4'b1111 || rd32_c !== 32'h0 || rd32_t !== 32'h0 ||
            rd64_c !== 64'h0 || rd64_t !== 64'h0 || st[0] !== cfu_pkg::CFU_OK ||
            st[1] !== cfu_pkg::CFU_OK || st[2] !== cfu_pkg::CFU_OK || st[3] !== cfu_pkg::CFU_OK) begin
            tests_failed++;
            $display("FAIL %s: got rv=%b rdy=%b d=%h/%h/%h/%h, want rv=0000 rdy=1111 d=0 ok",
                     tag, rv, rdy, rd32_c, rd32_t, rd64_c, rd64_t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        exp_q.delete();
        acc32 = '0;
        acc64 = '0;
        rst = 1'b0;
        #1;
        tests_run++;
        if (rdy !== 4'b1111) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b, want 1111", rdy);
        end
    endtask

    task automatic test_popcnt_basic();
        logic [31:0] vals [3];
        int          want [3];
        vals = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001};
        want = '{32, 0, 2};
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_func = 3'd0; a = {32'h0, vals[i]}; b = {$urandom, $urandom};
            resp_ready = 1'b1;
            tick();
            req_valid = 1'b0; req_func = 3'($urandom_range(0, 7)); a = {$urandom, $urandom};
            tests_run++;
            if (rv !== 4'b0000) begin
                tests_failed++;
                $display("FAIL popcnt_latency1: got resp_valid=%b, want 0000", rv);
            end
            tick();
            tests_run++;
            if (rv !== 4'b1111 || rd32_c !== 32'(want[i]) || rd32_t !== 32'(want[i]) ||
                rd64_c !== 64'(want[i]) || rd64_t !== 64'(want[i])) begin
                tests_failed++;
                $display("FAIL popcnt_latency2: got rv=%b d=%0d/%0d/%0d/%0d, want rv=1111 d=%0d",
                         rv, rd32_c, rd32_t, rd64_c, rd64_t, want[i]);
            end
            tick();
            tests_run++;
            if (rv !== 4'b0000) begin
                tests_failed++;
                $display("FAIL popcnt_empty: got resp_valid=%b, want 0000", rv);
            end
        end
    endtask

    task automatic test_hamming_popand();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_func = 3'd2; a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555;
        tick();
        req_func = 3'd1;
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (rv !== 4'b1111 || rd64_c !== 64'd64 || rd64_t !== 64'd64 || rd32_c !== 32'd32 || rd32_t !== 32'd32) begin
            tests_failed++;
            $display("FAIL hamming: got d=%0d/%0d/%0d/%0d, want 32/32/64/64", rd32_c, rd32_t, rd64_c, rd64_t);
        end
        tick();
        tests_run++;
        if (rv !== 4'b1111 || rd64_c !== 64'd0 || rd64_t !== 64'd0 || rd32_c !== 32'd0 || rd32_t !== 32'd0) begin
            tests_failed++;
            $display("FAIL popand: got d=%0d/%0d/%0d/%0d, want 0", rd32_c, rd32_t, rd64_c, rd64_t);
        end
        drain();
    endtask

    task automatic test_back_to_back_acc();
        logic [31:0] ops_a [5];
        logic [2:0]  ops_f [5];
        int          want  [5];
        ops_a = '{32'hF, 32'hFF, 32'hFFFF, 32'h0, 32'h0};
        ops_f = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd4};
        want  = '{4, 12, 28, 28, 0};
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                req_valid = 1'b1; req_func = ops_f[i]; a = {32'h0, ops_a[i]};
            end else begin
                req_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                tests_run++;
                if (rv !== 4'b1111 || rd32_c !== 32'(want[i-1]) || rd32_t !== 32'(want[i-1]) ||
                    rd64_c !== 64'(want[i-1]) || rd64_t !== 64'(want[i-1])) begin
                    tests_failed++;
                    $display("FAIL acc_b2b[%0d]: got rv=%b d=%0d/%0d/%0d/%0d, want rv=1111 d=%0d",
                             i - 1, rv, rd32_c, rd32_t, rd64_c, rd64_t, want[i-1]);
                end
            end
        end
        drain();
    endtask

    task automatic test_stall();
        logic [31:0] held32;
        logic [63:0] held64;
        resp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_func = 3'd0; a = {$urandom, $urandom};
            tick();
        end
        // First response now visible; hold it and offer the third op.
        req_valid = 1'b1; req_func = 3'd0; a = {$urandom, $urandom};
        resp_ready = 1'b0;
        #1;
        held32 = rd32_c;
        held64 = rd64_c;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rdy !== 4'b0000) begin
                tests_failed++;
                $display("FAIL stall_ready[%0d]: got %b, want 0000", i, rdy);
            end
            tick();
            tests_run++;
            if (rv !== 4'b1111 || rd32_c !== held32 || rd64_c !== held64) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got rv=%b d=%h/%h, want rv=1111 d=%h/%h",
                         i, rv, rd32_c, rd64_c, held32, held64);
            end
        end
        resp_ready = 1'b1;
        tick();
        drain();
    endtask

    task automatic test_error();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_func = 3'd3; a = 64'hFF;
        tick();
        req_func = 3'd6; a = {$urandom, $urandom}; b = {$urandom, $urandom};
        tick();
        req_func = 3'd4;
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (rv !== 4'b1111 || st[0] !== cfu_pkg::CFU_ERROR || st[3] !== cfu_pkg::CFU_ERROR ||
            rd32_c !== 32'h0 || rd64_t !== 64'h0) begin
            tests_failed++;
            $display("FAIL error_func: got s=%0d/%0d d=%h/%h, want s=%0d d=0",
                     st[0], st[3], rd32_c, rd64_t, cfu_pkg::CFU_ERROR);
        end
        tick();
        tests_run++;
        if (rv !== 4'b1111 || rd32_c !== 32'd8 || rd64_t !== 64'd8 || st[0] !== cfu_pkg::CFU_OK) begin
            tests_failed++;
            $display("FAIL error_acc_kept: got d=%0d/%0d s=%0d, want d=8 s=%0d", rd32_c, rd64_t, st[0], cfu_pkg::CFU_OK);
        end
        drain();
    endtask

    task automatic test_reset_midop();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_func = 3'd3; a = 64'hFFFF;
        tick();
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_midop");
        exp_q.delete();
        acc32 = '0;
        acc64 = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick();
        req_valid = 1'b1; req_func = 3'd4;
        tick();
        req_valid = 1'b0;
        tick();
        tests_run++;
        if (rv !== 4'b1111 || rd32_c !== 32'h0 || rd64_c !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_acc_cleared: got rv=%b d=%h/%h, want rv=1111 d=0", rv, rd32_c, rd64_c);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_func   = 3'($urandom_range(0, 7));
            a          = {$urandom, $urandom};
            b          = {$urandom, $urandom};
            resp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        acc32        = '0;
        acc64        = '0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_func     = '0;
        a            = '0;
        b            = '0;
        resp_ready   = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_popcnt_basic();
        test_hamming_popand();
        test_back_to_back_acc();
        test_stall();
        test_error();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
